// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: fills DEPTH words with a selectable pattern, reads them back and compares in order.
// Optional idle watchdog enabled by defining MEM_BIST_TIMEOUT_EN.
module mem_bist_ctrl #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 24,
    parameter int unsigned       DEPTH      = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]       CONST_PATT = 32'h00FFFFFF,
    parameter int unsigned       MAX_OUTST  = 4,
    parameter int unsigned       ERR_W      = 16
) (
    input  logic              clk_25_2m,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              wr_rdy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_rdy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTST);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] cmp_idx;
    logic [OUT_W-1:0] outst;
    logic             in_rd_phase;
    logic             active;
    logic             overrun;
    logic             mismatch;
    logic             err_hit;
    logic             fail_nxt;

    function automatic logic [DATA_W-1:0] patt(input logic [1:0] m, input logic [CNT_W-1:0] a);
        logic [DATA_W-1:0] p;
        logic [CNT_W-1:0]  sh;
        p  = '0;
        sh = a % CNT_W'(DATA_W);
        case (m)
            2'd0:    p = DATA_W'(CONST_PATT);
            2'd1:    p = DATA_W'(a[ADDR_W-1:0]);
            2'd2:    p = DATA_W'(1) << sh;
            default: for (int unsigned i = 0; i < DATA_W; i++) p[i] = i[0] ^ a[0];
        endcase
        return p;
    endfunction

    // Strobes gate registered state with rdy, so nothing is offered while the RAM is not ready.
    assign wr_en = (state == S_WRITE) && wr_rdy;
    assign rd_en = (state == S_READ) && rd_rdy && (outst < OUT_MAX);

    always_comb begin
        in_rd_phase = (state == S_READ) || (state == S_DRAIN);
        active      = rd_data_valid && (in_rd_phase || (state == S_DONE));
        overrun     = active && ((cmp_idx == DEPTH_C) || (state == S_DONE));
        mismatch    = active && !overrun && (rd_data != patt(mode_q, cmp_idx));
        err_hit     = overrun || mismatch;
        fail_nxt    = fail || err_hit;
    end

`ifdef MEM_BIST_TIMEOUT_EN
    logic [15:0] wdog;
`endif

    always_ff @(posedge clk_25_2m) begin
        if (!reset) begin
            state          <= S_IDLE;
            mode_q         <= '0;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            cmp_idx        <= '0;
            outst          <= '0;
            wr_addr        <= '0;
            wr_data        <= '0;
            rd_addr        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
`ifdef MEM_BIST_TIMEOUT_EN
            wdog           <= '0;
`endif
        end else begin
            // Compare/outstanding bookkeeping first; a start below overrides it.
            if (in_rd_phase) begin
                if (rd_en && !(rd_data_valid && outst != '0))
                    outst <= outst + 1'b1;
                else if (!rd_en && rd_data_valid && outst != '0)
                    outst <= outst - 1'b1;
            end
            if (active && !overrun)
                cmp_idx <= cmp_idx + 1'b1;
            if (err_hit) begin
                fail <= 1'b1;
                pass <= 1'b0;
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
            if (mismatch && !fail)
                first_err_addr <= BASE_ADDR + cmp_idx[ADDR_W-1:0];

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_q         <= mode;
                        wr_cnt         <= '0;
                        rd_cnt         <= '0;
                        cmp_idx        <= '0;
                        outst          <= '0;
                        wr_addr        <= BASE_ADDR;
                        wr_data        <= patt(mode, '0);
                        rd_addr        <= BASE_ADDR;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        state          <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_en) begin
                        wr_addr <= wr_addr + 1'b1;
                        wr_data <= patt(mode_q, wr_cnt + 1'b1);
                        wr_cnt  <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST)
                            state <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_en) begin
                        rd_addr <= rd_addr + 1'b1;
                        rd_cnt  <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cmp_idx == DEPTH_C) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= ~fail_nxt;
                    end
                end
                default: state <= S_IDLE;
            endcase

`ifdef MEM_BIST_TIMEOUT_EN
            if ((state == S_IDLE) || (state == S_DONE) || wr_en || rd_en || rd_data_valid) begin
                wdog <= '0;
            end else if (wdog == '1) begin
                wdog  <= '0;
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                fail  <= 1'b1;
                pass  <= 1'b0;
            end else begin
                wdog <= wdog + 1'b1;
            end
`endif
        end
    end

endmodule
